// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath,
// on-the-fly key schedule, IDLE/ROUND/DONE valid/ready control.
module aes128_iter_ctrl #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic [3:0]       round_idx
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t             fsm;
  fsm_t             fsm_nxt;
  logic [3:0]       idx_nxt;
  logic             load;
  logic             step;
  logic             last;
  logic [127:0]     state_reg;
  logic [KEY_W-1:0] rk_reg;
  logic [127:0]     rk_next;
  logic [127:0]     round_out;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_step(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] enc_round(
    input logic [127:0] s,
    input logic [127:0] rk,
    input logic         mix
  );
    logic [7:0]   sb [16];
    logic [127:0] sr;
    for (int i = 0; i < 16; i++)
      sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(r+4*c) -: 8] = sb[r + 4*((c + r) % 4)];
    if (mix)
      for (int c = 0; c < 4; c++)
        sr[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    return sr ^ rk;
  endfunction

  assign last      = (round_idx == LAST);
  assign rk_next   = key_step(rk_reg, rcon(round_idx));
  assign round_out = enc_round(state_reg, rk_next, !last);

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_data  = state_reg;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      round_idx <= 4'd0;
    end else begin
      fsm       <= fsm_nxt;
      round_idx <= idx_nxt;
    end
  end

  // Next state, round counter and datapath enables; flush wins.
  always_comb begin
    fsm_nxt = fsm;
    idx_nxt = round_idx;
    load    = 1'b0;
    step    = 1'b0;
    if (flush) begin
      fsm_nxt = IDLE;
      idx_nxt = 4'd0;
    end else begin
      unique case (fsm)
        IDLE: if (in_valid) begin
          fsm_nxt = ROUND;
          idx_nxt = 4'd1;
          load    = 1'b1;
        end
        ROUND: begin
          step = 1'b1;
          if (last) fsm_nxt = DONE;
          else      idx_nxt = round_idx + 4'd1;
        end
        DONE: if (out_ready) begin
          fsm_nxt = IDLE;
          idx_nxt = 4'd0;
        end
        default: begin
          fsm_nxt = IDLE;
          idx_nxt = 4'd0;
        end
      endcase
    end
  end

  // Cipher state and round key; untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      rk_reg    <= '0;
    end else if (load) begin
      state_reg <= in_data ^ in_key;
      rk_reg    <= in_key;
    end else if (step) begin
      state_reg <= round_out;
      rk_reg    <= rk_next;
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: FIPS-197 vectors, backpressure,
// flush, async reset and random blocks against a byte-level model.
module tb_aes128_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round_idx;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RC = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;

  aes128_iter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sb[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  endtask

  task automatic aes_ref(
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic [127:0] ct,
    output logic [127:0] lastk
  );
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [7:0]  s [4][4];
    logic [7:0]  n [4][4];
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          n[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, n[r][c]) ^ gmul(8'h03, n[(r+1)%4][c])
                    ^ n[(r+2)%4][c] ^ n[(r+3)%4][c];
          else
            s[r][c] = n[r][c];
        end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127-8*(r+4*c) -: 8] = s[r][c];
    lastk = {w[40], w[41], w[42], w[43]};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] k, input logic [127:0] p,
                        input string tag);
    int waited;
    waited   = 0;
    in_data  = p;
    in_key   = k;
    in_valid = 1'b1;
    while (!in_ready && waited < 30) begin
      tick();
      waited++;
    end
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    chk({tag, " idx1"}, 128'(round_idx), 128'(1));
    chk({tag, " busy"}, 128'(busy), 128'(1'b1));
  endtask

  task automatic rounds(input logic [127:0] ct, input logic [127:0] lk,
                        input bit tog, input string tag);
    for (int k = 1; k <= 10; k++) begin
      if (tog) begin
        in_data  = rnd128();
        in_key   = rnd128();
        in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      if (k < 10) begin
        chk({tag, " early ov"}, 128'(out_valid), 128'(1'b0));
        chk({tag, " idx"}, 128'(round_idx), 128'(k + 1));
      end
    end
    in_valid = 1'b0;
    chk({tag, " ov"}, 128'(out_valid), 128'(1'b1));
    chk({tag, " idx10"}, 128'(round_idx), 128'(10));
    chk({tag, " ct"}, out_data, ct);
    chk({tag, " rk"}, dut.rk_reg, lk);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " hs ir"}, 128'(in_ready), 128'(1'b1));
    chk({tag, " hs ov"}, 128'(out_valid), 128'(1'b0));
    chk({tag, " hs idx"}, 128'(round_idx), 128'(0));
  endtask

  task automatic b2b(input logic [127:0] k, input logic [127:0] p,
                     input string tag);
    in_data   = p;
    in_key    = k;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk({tag, " b2b ir"}, 128'(in_ready), 128'(1'b1));
    chk({tag, " b2b ov"}, 128'(out_valid), 128'(1'b0));
    chk({tag, " b2b idx0"}, 128'(round_idx), 128'(0));
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, " b2b idx1"}, 128'(round_idx), 128'(1));
    chk({tag, " b2b busy"}, 128'(busy), 128'(1'b1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct, lk, k, p;
    int           seen;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_key    = '0;
    build_sbox();

    tick();
    tick();
    chk("rst ov", 128'(out_valid), 128'(1'b0));
    chk("rst ir", 128'(in_ready), 128'(1'b1));
    chk("rst busy", 128'(busy), 128'(1'b0));
    chk("rst idx", 128'(round_idx), 128'(0));
    chk("rst data", out_data, 128'(0));
    #3;
    rst_n = 1'b1;
    tick();

    aes_ref(KB, PB, ct, lk);
    accept(KB, PB, "appB");
    rounds(CB, lk, 1'b0, "appB");

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp data", out_data, CB);
      chk("bp ir", 128'(in_ready), 128'(1'b0));
      chk("bp ov", 128'(out_valid), 128'(1'b1));
    end

    b2b(KC, PC, "appC");
    rounds(CC, RC, 1'b0, "appC");
    aes_ref(KB, PB, ct, lk);
    b2b(KB, PB, "appB2");
    rounds(CB, lk, 1'b0, "appB2");
    handshake("appB2");

    accept(rnd128(), rnd128(), "fl");
    repeat (4) tick();
    chk("fl idx5", 128'(round_idx), 128'(5));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl ir", 128'(in_ready), 128'(1'b1));
    chk("fl ov", 128'(out_valid), 128'(1'b0));
    chk("fl busy", 128'(busy), 128'(1'b0));
    chk("fl idx", 128'(round_idx), 128'(0));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    chk("fl no pulse", 128'(seen), 128'(0));
    accept(KB, PB, "flB");
    rounds(CB, lk, 1'b0, "flB");
    handshake("flB");

    in_valid = 1'b1;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flacc ir", 128'(in_ready), 128'(1'b1));
    chk("flacc idx", 128'(round_idx), 128'(0));

    k = rnd128();
    p = rnd128();
    aes_ref(k, p, ct, lk);
    accept(k, p, "fldone");
    rounds(ct, lk, 1'b0, "fldone");
    flush     = 1'b1;
    out_ready = 1'b0;
    tick();
    flush     = 1'b0;
    chk("fldone ov", 128'(out_valid), 128'(1'b0));
    chk("fldone ir", 128'(in_ready), 128'(1'b1));

    accept(KC, PC, "ar");
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar ov", 128'(out_valid), 128'(1'b0));
    chk("ar ir", 128'(in_ready), 128'(1'b1));
    chk("ar idx", 128'(round_idx), 128'(0));
    chk("ar busy", 128'(busy), 128'(1'b0));
    #2;
    rst_n = 1'b1;
    tick();
    accept(KC, PC, "arC");
    rounds(CC, RC, 1'b0, "arC");
    handshake("arC");

    aes_ref(KB, PB, ct, lk);
    accept(KB, PB, "togB");
    rounds(CB, lk, 1'b1, "togB");
    handshake("togB");

    for (int i = 0; i < 6; i++) begin
      k = rnd128();
      p = rnd128();
      aes_ref(k, p, ct, lk);
      accept(k, p, "rnd");
      rounds(ct, lk, 1'b1, "rnd");
      handshake("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
